// File: rtl/piso_pkg.sv
// Shared types and default parameters for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } piso_state_e;

  localparam int unsigned DEF_WIDTH        = 4;
  localparam int unsigned DEF_CLKS_PER_BIT = 2;

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter: tick_o pulses on the last cycle of every CLKS_PER_BIT-cycle bit slot.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && !clr_i && (cnt_q == CNT_LAST);

  // Held at zero while disabled so every frame starts on a clean bit slot.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Serial frame transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1).
// Handshake: a word is taken on a posedge where in_valid && in_ready; in_ready is high only in IDLE.
module piso_tx
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  piso_state_e      state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;
  assign tx       = tx_q;
  assign done     = done_q;
  assign state_o  = state_q;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (busy),
    .clr_i (accept),
    .tick_o(tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = d;
          bit_cnt_d = '0;
        end
      end
      START: begin
        if (tick) state_d = DATA;
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // tx is registered from the upcoming state so the line changes with the state itself.
    tx_d = (state_d == DATA) ? shift_d[0] : (state_d != START);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: WIDTH=4/CLKS_PER_BIT=2 instance plus a CLKS_PER_BIT=1 instance.
module tb_piso_tx;

  logic       clk;
  logic       rst_n;
  logic [3:0] d1, d2;
  logic       iv1, iv2;
  logic       rdy1, rdy2, tx1, tx2, busy1, busy2, done1, done2;
  logic [1:0] st1, st2;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       iv;
    logic [3:0] d;
    logic       tx;
    logic       busy;
    logic       done;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .in_valid(iv1), .in_ready(rdy1),
    .tx(tx1), .busy(busy1), .done(done1), .state_o(st1)
  );

  piso_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .d(d2), .in_valid(iv2), .in_ready(rdy2),
    .tx(tx2), .busy(busy2), .done(done2), .state_o(st2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic tx_e, input logic busy_e,
                      input logic done_e, input logic rdy_e);
    chk({tag, " tx"},    {7'd0, tx1},   {7'd0, tx_e});
    chk({tag, " busy"},  {7'd0, busy1}, {7'd0, busy_e});
    chk({tag, " done"},  {7'd0, done1}, {7'd0, done_e});
    chk({tag, " ready"}, {7'd0, rdy1},  {7'd0, rdy_e});
  endtask

  task automatic add_row(input logic iv, input logic [3:0] dd, input logic t,
                         input logic b, input logic dn, input logic r);
    vec_t v;
    v.iv = iv; v.d = dd; v.tx = t; v.busy = b; v.done = dn; v.rdy = r;
    vecs.push_back(v);
  endtask

  // Twelve busy cycles of a frame; pat[11] is the tx value of the first cycle after accept.
  task automatic add_frame(input logic iv, input logic [3:0] dd, input logic [11:0] pat);
    for (int k = 0; k < 12; k++) add_row(iv, dd, pat[11-k], 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [11:0] pat12;
    logic [5:0]  pat6;

    // Expected tx sequences, hand-derived: start 0,0 / 4 data bits LSB first x2 / stop 1,1.
    // 1010 -> 0,0,0,0,1,1,0,0,1,1,1,1 ; while d=1111/in_valid=1 is driven mid-frame.
    add_row(1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
    add_frame(1'b1, 4'b1111, 12'b0000_1100_1111);
    add_row(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    add_row(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    // in_valid held: 0001 -> 0,0,1,1,0,0,0,0,0,0,1,1 then 1110 accepted in the done cycle.
    add_row(1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
    add_frame(1'b1, 4'b1110, 12'b0011_0000_0011);
    add_row(1'b1, 4'b1110, 1'b1, 1'b0, 1'b1, 1'b1);
    add_frame(1'b0, 4'b0000, 12'b0000_1111_1111);
    add_row(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    add_row(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);

    rst_n = 1'b0;
    d1 = '0; d2 = '0; iv1 = 1'b0; iv2 = 1'b0;
    #12;
    chk1("reset", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("reset state", {6'd0, st1}, 8'd0);
    chk("reset dut2 tx", {7'd0, tx2}, 8'd1);
    chk("reset dut2 busy", {7'd0, busy2}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 20 idle cycles: line high, never busy, no done
    for (int i = 0; i < 20; i++) begin
      chk1($sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
    end

    // table-driven frames
    for (int i = 0; i < vecs.size(); i++) begin
      chk1($sformatf("row%0d", i), vecs[i].tx, vecs[i].busy, vecs[i].done, vecs[i].rdy);
      iv1 = vecs[i].iv;
      d1  = vecs[i].d;
      tick();
    end

    // reset asserted between edges while in DATA
    iv1 = 1'b1; d1 = 4'b1010;
    tick();
    iv1 = 1'b0;
    repeat (4) tick();
    chk("pre-reset busy", {7'd0, busy1}, 8'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk1("async reset", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("async reset state", {6'd0, st1}, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk1("post-release", 1'b1, 1'b0, 1'b0, 1'b1);
    // 0110 -> 0,0,0,0,1,1,1,1,0,0,1,1
    pat12 = 12'b0000_1111_0011;
    iv1 = 1'b1; d1 = 4'b0110;
    tick();
    iv1 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      chk1($sformatf("recov c%0d", k + 1), pat12[11-k], 1'b1, 1'b0, 1'b0);
      tick();
    end
    chk1("recov done", 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    chk1("recov after", 1'b1, 1'b0, 1'b0, 1'b1);

    // CLKS_PER_BIT=1: 0110 -> 0,0,1,1,0,1, done at cycle 7
    pat6 = 6'b001101;
    iv2 = 1'b1; d2 = 4'b0110;
    tick();
    iv2 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("cpb1 c%0d tx", k + 1), {7'd0, tx2}, {7'd0, pat6[5-k]});
      chk($sformatf("cpb1 c%0d busy", k + 1), {7'd0, busy2}, 8'd1);
      chk($sformatf("cpb1 c%0d done", k + 1), {7'd0, done2}, 8'd0);
      tick();
    end
    chk("cpb1 done", {7'd0, done2}, 8'd1);
    chk("cpb1 idle busy", {7'd0, busy2}, 8'd0);
    chk("cpb1 idle ready", {7'd0, rdy2}, 8'd1);
    chk("cpb1 idle state", {6'd0, st2}, 8'd0);
    tick();
    chk("cpb1 done drop", {7'd0, done2}, 8'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of data bits per frame (legal range 1..16).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 2, clock cycles each serial bit is held (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port d  input  WIDTH  parallel data word to transmit.
REQ-006 SHALL have port in_valid  input  1  d holds a word to send.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port tx  output  1  registered serial line, idle high.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a frame's stop bit completes.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP.
REQ-012 SHALL drive in_ready = 1 only in IDLE; busy = 1 in START, DATA and STOP.
REQ-013 SHALL accept a word when in_valid and in_ready are both 1 at a posedge: d latched into the shift register, bit counter and cycle counter cleared, state to START.
REQ-014 SHALL ignore in_valid and changes on d outside IDLE; the latched word is unaffected.
REQ-015 SHALL hold tx = 0 for CLKS_PER_BIT cycles in START, starting the cycle after acceptance.
REQ-016 SHALL send WIDTH data bits LSB first in DATA, each held CLKS_PER_BIT cycles, shifting right after each bit.
REQ-017 SHALL hold tx = 1 for CLKS_PER_BIT cycles in STOP, then return to IDLE.
REQ-018 SHALL pulse done = 1 for exactly the first IDLE cycle after STOP completes.
REQ-019 SHALL make frame length exactly (WIDTH+2)*CLKS_PER_BIT cycles from acceptance to done.
REQ-020 SHALL allow back-to-back frames: a word accepted in the done cycle starts START on the next cycle, with no extra idle bit.
REQ-021 SHALL hold tx = 1 in IDLE.
REQ-022 SHALL wrap the cycle counter at CLKS_PER_BIT-1 to 0 with no off-by-one.
REQ-023 SHALL treat the bit counter's last value as WIDTH-1; the counter width is $clog2(WIDTH+1).
REQ-024 SHALL produce no X on any output after reset for any d value, including all-zeros and all-ones.

Reset
REQ-025 SHALL, while rst_n = 0, immediately force state IDLE, tx = 1, busy = 0, done = 0, in_ready = 1, and zero the counters and shift register.
REQ-026 SHALL abort any frame in progress when rst_n is asserted mid-frame; tx returns high without waiting for a clock edge.
REQ-027 SHALL resume normal operation on the first posedge clk after rst_n deasserts.

Structure
REQ-028 SHALL place the state enum (IDLE, START, DATA, STOP) and the default WIDTH and CLKS_PER_BIT constants in shared package piso_pkg.
REQ-029 SHALL use one sub-module, bit_timer: a cycle counter with a one-cycle tick output every CLKS_PER_BIT cycles, cleared on frame accept.
REQ-030 SHALL register tx directly; tx SHALL NOT be driven combinationally from state.

Verification
REQ-031 SHALL cover: WIDTH=4, CLKS_PER_BIT=2, d=4'b1010 accepted at cycle 0 -> tx over cycles 1..12 = 0,0,0,0,1,1,0,0,1,1,1,1; done high at cycle 13; busy high cycles 1..12.
REQ-032 SHALL cover: in_valid held high with d=4'b0001 then 4'b1110 -> two contiguous frames; second start bit begins the cycle after the first done; no idle gap.
REQ-033 SHALL cover: d changed to 4'b1111 mid-frame with in_valid=1 -> serial output still matches the original word; in_ready stays 0 until IDLE.
REQ-034 SHALL cover: rst_n pulled low during DATA between clock edges -> tx=1, busy=0, in_ready=1 immediately; a new word after release sends a clean frame.
REQ-035 SHALL cover: CLKS_PER_BIT=1, WIDTH=4, d=4'b0110 -> frame 6 cycles long: 0,0,1,1,0,1; done at cycle 7.
REQ-036 SHALL cover: in_valid=0 for 20 cycles after reset -> tx=1, busy=0, done never pulses.
